// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the round-robin ALU arbiter: FSM states,
// datapath widths and the named ALU select codes.
package alu_arb_pkg;

    localparam int ALU_W = 4;
    localparam int Y_W   = 5;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

    // Bit 3 clear: arithmetic group; bit 3 set: logical group.
    localparam logic [ALU_W-1:0] SEL_INC_A  = 4'b0000;
    localparam logic [ALU_W-1:0] SEL_DEC_A  = 4'b0001;
    localparam logic [ALU_W-1:0] SEL_PASS_A = 4'b0010;
    localparam logic [ALU_W-1:0] SEL_PASS_B = 4'b0011;
    localparam logic [ALU_W-1:0] SEL_NEG_A  = 4'b0100;
    localparam logic [ALU_W-1:0] SEL_SUB    = 4'b0101;
    localparam logic [ALU_W-1:0] SEL_ADD    = 4'b0110;
    localparam logic [ALU_W-1:0] SEL_SHL_A  = 4'b0111;
    localparam logic [ALU_W-1:0] SEL_NOT_A  = 4'b1000;
    localparam logic [ALU_W-1:0] SEL_NOT_B  = 4'b1001;
    localparam logic [ALU_W-1:0] SEL_AND    = 4'b1010;
    localparam logic [ALU_W-1:0] SEL_OR     = 4'b1011;
    localparam logic [ALU_W-1:0] SEL_XOR    = 4'b1100;
    localparam logic [ALU_W-1:0] SEL_NAND   = 4'b1101;
    localparam logic [ALU_W-1:0] SEL_XNOR   = 4'b1110;
    localparam logic [ALU_W-1:0] SEL_NOR    = 4'b1111;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request at or above ptr_i,
// wrapping around, yields a one-hot grant and its encoded index.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    int cand;

    // NOTE: every output gets a default before the search loop so no path
    // through the block leaves a value unassigned and infers a latch.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (int'(ptr_i) + k) % NREQ;
            if (!any_o && req_i[cand]) begin
                any_o          = 1'b1;
                grant_o[cand]  = 1'b1;
                idx_o          = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external combinational ALU among NREQ requesters.
// Define ALU_ARB_STATS_EN to add the saturating op_count output.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [ALU_W*NREQ-1:0] req_a,
    input  logic [ALU_W*NREQ-1:0] req_b,
    input  logic [ALU_W*NREQ-1:0] req_sel,
    output logic [ALU_W-1:0]      alu_a,
    output logic [ALU_W-1:0]      alu_b,
    output logic [ALU_W-1:0]      alu_sel,
    input  logic [Y_W-1:0]        alu_y,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [Y_W-1:0]        rsp_y,
    output logic [IDW-1:0]        rsp_id
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0]           op_count
`endif
);

    state_e           state_q,     state_d;
    logic [IDW-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [ALU_W-1:0] op_a_q,      op_a_d;
    logic [ALU_W-1:0] op_b_q,      op_b_d;
    logic [ALU_W-1:0] op_sel_q,    op_sel_d;
    logic [IDW-1:0]   op_id_q,     op_id_d;
    logic [Y_W-1:0]   rsp_y_q,     rsp_y_d;
    logic [IDW-1:0]   rsp_id_q,    rsp_id_d;
    logic             rsp_valid_q, rsp_valid_d;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   win_idx;
    logic             win_any;
    int               win_int;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (win_idx),
        .any_o   (win_any)
    );

    assign win_int = int'(win_idx);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_sel_d    = op_sel_q;
        op_id_d     = op_id_q;
        rsp_y_d     = rsp_y_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        req_ready   = '0;
        unique case (state_q)
            IDLE: begin
                req_ready = grant;
                if (win_any) begin
                    op_a_d   = req_a[win_int*ALU_W +: ALU_W];
                    op_b_d   = req_b[win_int*ALU_W +: ALU_W];
                    op_sel_d = req_sel[win_int*ALU_W +: ALU_W];
                    op_id_d  = win_idx;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_y_d     = alu_y;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                rr_ptr_d    = (op_id_q == IDW'(NREQ - 1)) ? '0 : op_id_q + 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_sel_q    <= '0;
            op_id_q     <= '0;
            rsp_y_q     <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_sel_q    <= op_sel_d;
            op_id_q     <= op_id_d;
            rsp_y_q     <= rsp_y_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // ALU inputs come straight from the op registers, so they stay quiet
    // outside EXEC without any extra gating.
    assign alu_a     = op_a_q;
    assign alu_b     = op_b_q;
    assign alu_sel   = op_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_id    = rsp_id_q;

`ifdef ALU_ARB_STATS_EN
    logic [15:0] op_count_q, op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        if (rsp_valid_q && rsp_ready && (op_count_q != 16'hFFFF)) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: expected responses are queued at grant time
// and a separate monitor compares them on every response handshake.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct {
        logic [Y_W-1:0] y;
        logic [IDW-1:0] id;
    } exp_t;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [ALU_W*NREQ-1:0] req_a;
    logic [ALU_W*NREQ-1:0] req_b;
    logic [ALU_W*NREQ-1:0] req_sel;
    logic [ALU_W-1:0]      alu_a;
    logic [ALU_W-1:0]      alu_b;
    logic [ALU_W-1:0]      alu_sel;
    logic [Y_W-1:0]        alu_y;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [Y_W-1:0]        rsp_y;
    logic [IDW-1:0]        rsp_id;
`ifdef ALU_ARB_STATS_EN
    logic [15:0]           op_count;
`endif

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    exp_t exp_q[$];

    alu_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_y     (alu_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id)
`ifdef ALU_ARB_STATS_EN
        ,
        .op_count  (op_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Shared ALU: operands sign-extended to 5 bits for both groups.
    always_comb begin
        logic [4:0] sa, sb;
        sa = {alu_a[3], alu_a};
        sb = {alu_b[3], alu_b};
        alu_y = '0;
        case (alu_sel)
            SEL_INC_A:  alu_y = sa + 5'd1;
            SEL_DEC_A:  alu_y = sa - 5'd1;
            SEL_PASS_A: alu_y = sa;
            SEL_PASS_B: alu_y = sb;
            SEL_NEG_A:  alu_y = -sa;
            SEL_SUB:    alu_y = sa - sb;
            SEL_ADD:    alu_y = sa + sb;
            SEL_SHL_A:  alu_y = {alu_a, 1'b0};
            SEL_NOT_A:  alu_y = ~sa;
            SEL_NOT_B:  alu_y = ~sb;
            SEL_AND:    alu_y = sa & sb;
            SEL_OR:     alu_y = sa | sb;
            SEL_XOR:    alu_y = sa ^ sb;
            SEL_NAND:   alu_y = ~(sa & sb);
            SEL_XNOR:   alu_y = ~(sa ^ sb);
            default:    alu_y = ~(sa | sb);
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every response handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", {27'd0, rsp_y}, 32'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_y", {27'd0, rsp_y}, {27'd0, e.y});
                check("rsp_id", {30'd0, rsp_id}, {30'd0, e.id});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int id, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] sel);
        req_a[id*4 +: 4]   = a;
        req_b[id*4 +: 4]   = b;
        req_sel[id*4 +: 4] = sel;
    endtask

    task automatic push(input int id, input logic [4:0] y);
        exp_t e;
        e.y  = y;
        e.id = IDW'(id);
        exp_q.push_back(e);
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 30 && exp_q.size() != 0; c++) @(negedge clk);
        check("drain_timeout", exp_q.size(), 0);
        tick();
    endtask

    // Single requester op: bounded wait for its grant, then let it complete.
    task automatic do_op(input int id, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] sel, input logic [4:0] y);
        bit got;
        got = 1'b0;
        set_op(id, a, b, sel);
        req_valid = 4'b0001 << id;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1'b1;
            else tick();
        end
        check("op_grant", {31'd0, got}, 1);
        if (got) push(id, y);
        tick();
        req_valid = '0;
        wait_drain();
    endtask

    initial begin
        logic [3:0] exp_gnt;
        int rr_order[5];
        logic [4:0] rr_y[4];
        int ng, last;

        rr_order = '{0, 1, 2, 3, 0};
        rr_y     = '{5'h03, 5'h06, 5'h17, 5'h1A};

        rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
        req_a = '0; req_b = '0; req_sel = '0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        check("rst_rsp_y", {27'd0, rsp_y}, 0);
        check("rst_rsp_id", {30'd0, rsp_id}, 0);
        check("rst_alu_a", {28'd0, alu_a}, 0);
        check("rst_alu_b", {28'd0, alu_b}, 0);
        check("rst_alu_sel", {28'd0, alu_sel}, 0);
        check("rst_req_ready", {28'd0, req_ready}, 0);
`ifdef ALU_ARB_STATS_EN
        check("rst_op_count", {16'd0, op_count}, 0);
`endif

        // Single op from requester 1: 3 + 5 = 8
        tick();
        set_op(1, 4'h3, 4'h5, SEL_ADD);
        req_valid = 4'b0010;
        @(negedge clk);
        check("single_ready", {28'd0, req_ready}, 32'h2);
        push(1, 5'h08);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("exec_alu_a", {28'd0, alu_a}, 32'h3);
        check("exec_alu_b", {28'd0, alu_b}, 32'h5);
        check("exec_alu_sel", {28'd0, alu_sel}, {28'd0, SEL_ADD});
        check("exec_rsp_valid", {31'd0, rsp_valid}, 0);
        tick();
        @(negedge clk);
        check("t2_rsp_valid", {31'd0, rsp_valid}, 1);
        wait_drain();
        @(negedge clk);
        check("idle_alu_hold", {28'd0, alu_a}, 32'h3);

        // Round robin from a fresh pointer, all four requesters valid.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_op(0, 4'h1, 4'h2, SEL_ADD);
        set_op(1, 4'h7, 4'h1, SEL_SUB);
        set_op(2, 4'h8, 4'h0, SEL_DEC_A);
        set_op(3, 4'h5, 4'h0, SEL_NOT_A);
        req_valid = 4'b1111;
        ng = 0;
        last = 0;
        for (int c = 0; c < 60 && ng < 5; c++) begin
            @(negedge clk);
            if (req_ready != 0) begin
                exp_gnt = 4'b0001 << rr_order[ng];
                check("rr_grant", {28'd0, req_ready}, {28'd0, exp_gnt});
                if (ng > 0) check("rr_gap", last == 0 ? 0 : cyc - last, 3);
                last = cyc;
                push(rr_order[ng], rr_y[rr_order[ng]]);
                ng++;
            end
        end
        check("rr_grants_seen", ng, 5);
        tick();
        req_valid = '0;
        wait_drain();

        // Backpressure: requester 2 AND (9 & 3 = 1), stalled 5 cycles in RESP.
        rsp_ready = 1'b0;
        set_op(2, 4'h9, 4'h3, SEL_AND);
        set_op(0, 4'hF, 4'h1, SEL_XOR);
        req_valid = 4'b0100;
        @(negedge clk);
        check("bp_ready", {28'd0, req_ready}, 32'h4);
        push(2, 5'h01);
        tick();
        req_valid = 4'b0001;
        @(negedge clk);
        check("bp_exec_ready", {28'd0, req_ready}, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, rsp_valid}, 1);
            check("bp_y_stable", {27'd0, rsp_y}, 32'h01);
            check("bp_id_stable", {30'd0, rsp_id}, 32'h2);
            check("bp_no_ready", {28'd0, req_ready}, 0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        check("bp_next_grant", {28'd0, req_ready}, 32'h1);
        push(0, 5'h1E);
        tick();
        req_valid = '0;
        wait_drain();

        // Reset during EXEC: op discarded, pointer back to 0.
        set_op(3, 4'h2, 4'h2, SEL_ADD);
        req_valid = 4'b1000;
        @(negedge clk);
        check("mid_ready", {28'd0, req_ready}, 32'h8);
        tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rsp_valid", {31'd0, rsp_valid}, 0);
        check("mid_alu_a", {28'd0, alu_a}, 0);
        repeat (4) tick();
        @(negedge clk);
        check("mid_no_rsp", {31'd0, rsp_valid}, 0);
        tick();
        req_valid = 4'b0011;
        @(negedge clk);
        check("mid_ptr_zero", {28'd0, req_ready}, 32'h1);
        push(0, 5'h1E);
        tick();
        req_valid = '0;
        wait_drain();

        do_op(1, 4'hB, 4'h0, SEL_SHL_A, 5'h16);
        do_op(2, 4'h4, 4'h2, SEL_OR, 5'h06);
`ifdef ALU_ARB_STATS_EN
        @(negedge clk);
        check("op_count_3", {16'd0, op_count}, 3);
`endif

        repeat (3) tick();
        check("queue_empty_end", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational 4-bit ALU among NREQ requesters using round-robin arbitration. It accepts one operation at a time through per-requester valid/ready handshakes. It drives the ALU operand and select inputs from registered values and captures the 5-bit result. It returns the result with the winner's ID on a single response channel with backpressure.

## Interface
Parameters:
- NREQ, 4: number of requesters; legal range 2..8.
- IDW, $clog2(NREQ): requester ID width (derived; do not override).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_a  in  4*NREQ  operand A, slice i belongs to requester i.
- req_b  in  4*NREQ  operand B, slice i.
- req_sel  in  4*NREQ  ALU select, slice i. Bit 3 = 0 selects arithmetic, 1 selects logical.
- alu_a  out  4  operand A to shared ALU.
- alu_b  out  4  operand B to shared ALU.
- alu_sel  out  4  select to shared ALU.
- alu_y  in  5  ALU result; combinational function of alu_a/alu_b/alu_sel.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_y  out  5  captured ALU result.
- rsp_id  out  IDW  requester index that issued the op.
- op_count  out  16  completed-op counter; present only with ALU_ARB_STATS_EN.

## Operation
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - Winner is the first requester with req_valid=1, searching from rr_ptr upward with wrap-around.
  - req_ready[winner]=1, combinational from req_valid and rr_ptr. All other bits are 0.
  - On a transfer (valid & ready), latch a/b/sel/id into op registers and go to EXEC.
  - If no request is valid, stay in IDLE.
- EXEC:
  - alu_a/alu_b/alu_sel are driven from the op registers.
  - Capture alu_y into rsp_y, set rsp_id, assert rsp_valid, go to RESP.
  - rr_ptr becomes (winner+1) mod NREQ.
- RESP:
  - rsp_valid=1. rsp_y and rsp_id stay stable until rsp_valid & rsp_ready.
  - On that cycle, drop rsp_valid and go to IDLE.
  - All req_ready bits are 0 in EXEC and RESP.
- Requesters must hold req_valid and their operands stable until accepted. Dropping valid before acceptance is allowed; the arbiter ignores that requester.
- alu_a/alu_b/alu_sel hold their last op-register value outside EXEC. No toggling when idle.
- Widths: operands pass through unmodified. rsp_y is the full 5-bit alu_y; no truncation or extension inside this block.
- All 16 sel codes are legal and forwarded verbatim.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0, rsp_valid=0, rsp_y=0, rsp_id=0.
  - alu_a=0, alu_b=0, alu_sel=0, req_ready=0 (valid-gated), op_count=0.
- Latency: request accepted in cycle T, ALU driven in T+1, rsp_valid high in T+2.
- Throughput: at best one op per 3 cycles with rsp_ready held high (IDLE→EXEC→RESP→IDLE).
- rsp_ready low stalls in RESP indefinitely. No requests are accepted while stalled.
- Simultaneous requests: only one is granted per IDLE cycle. The others wait and are served in round-robin order.
- rst asserted in any state returns the block to the reset state on the next edge. Any in-flight op and response are discarded, and nothing is replayed.

## Configuration
- ALU_ARB_STATS_EN defined:
  - op_count increments on every response handshake (rsp_valid & rsp_ready).
  - It saturates at 16'hFFFF and clears on rst.
- Not defined: the op_count port and counter logic are absent. Behaviour is otherwise identical.

## Structure
- Package alu_arb_pkg holds:
  - state enum (IDLE, EXEC, RESP);
  - ALU_W=4 and Y_W=5;
  - named select constants: SEL_INC_A=4'b0000 … SEL_ADD=4'b0110, SEL_SHL_A=4'b0111, SEL_NOT_A=4'b1000 … SEL_NOR=4'b1111.
- One sub-module: rr_pick, a combinational round-robin priority picker.
  - Inputs: NREQ-bit request vector and rr_ptr.
  - Outputs: one-hot grant and encoded index.

## Test plan
- Single op: rst, then req_valid[1] with a=4'h3, b=4'h5, sel=SEL_ADD. Expect req_ready[1] the same cycle, rsp_valid at T+2 with rsp_y=5'h08 and rsp_id=1.
- Round-robin: all four requesters valid continuously with rsp_ready=1. Grant order is 0,1,2,3,0, one grant every 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles in RESP. rsp_y and rsp_id stay stable, req_ready stays 0, and the op completes when rsp_ready rises.
- Sign/logic path: sel=SEL_DEC_A with a=4'h8 gives rsp_y=5'h17. sel=SEL_NOT_A with a=4'h5 gives rsp_y=5'h1A.
- Reset mid-op: assert rst during EXEC. Next cycle expect state=IDLE, rsp_valid=0, rr_ptr=0, and no response is ever produced for that op.
- Stats (ALU_ARB_STATS_EN): 3 completed ops give op_count=3. Forced near 16'hFFFF, the counter saturates.
